// File: rtl/_5bit_and_checker_pkg.sv
// Shared definitions for the 5-bit AND response checker: default widths and
// the FSM state encoding that other blocks and benches can refer to.
`ifndef DELAY
`define DELAY 1
`endif

package _5bit_and_checker_pkg;

  localparam int WIDTH_DEF = 5;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

endpackage

// File: rtl/_5bit_and_golden.sv
// Golden model for a bitwise AND unit: recomputes A & B and flags every bit
// where the observed result differs.
module _5bit_and_golden
  import _5bit_and_checker_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] inp_a,
  input  logic [WIDTH-1:0] inp_b,
  input  logic [WIDTH-1:0] dut_out,
  output logic [WIDTH-1:0] mask,
  output logic             diff
);

  logic [WIDTH-1:0] expected;

  always_comb begin
    expected = inp_a & inp_b;
    mask     = expected ^ dut_out;
    diff     = |mask;
  end

endmodule

// File: rtl/_5bit_and_checker.sv
// Self-checking observer for the 5-bit AND datapath: checks one triple every
// two cycles, keeps saturating pass/fail counts and the first failing vector.
module _5bit_and_checker
  import _5bit_and_checker_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] InpA,
  input  logic [WIDTH-1:0] InpB,
  input  logic [WIDTH-1:0] dut_out,
  input  logic             finish,
  output logic             report_valid,
  input  logic             report_ready,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_sticky,
  output logic [WIDTH-1:0] first_fail_a,
  output logic [WIDTH-1:0] first_fail_b,
  output logic [WIDTH-1:0] first_fail_out,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             mismatch,
  output logic [WIDTH-1:0] mismatch_mask,
  output state_e           dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // report_valid stays high with stable fields until report_ready is seen.

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cap_a_q, cap_a_d;
  logic [WIDTH-1:0] cap_b_q, cap_b_d;
  logic [WIDTH-1:0] cap_out_q, cap_out_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic             sticky_q, sticky_d;
  logic [WIDTH-1:0] ff_a_q, ff_a_d;
  logic [WIDTH-1:0] ff_b_q, ff_b_d;
  logic [WIDTH-1:0] ff_out_q, ff_out_d;
  logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             pend_q, pend_d;

  logic [WIDTH-1:0] chk_mask;
  logic             chk_diff;
  logic [CNT_W:0]   vec_sum;
  logic [CNT_W-1:0] vec_idx;

  _5bit_and_golden #(.WIDTH(WIDTH)) u_golden (
    .inp_a   (cap_a_q),
    .inp_b   (cap_b_q),
    .dut_out (cap_out_q),
    .mask    (chk_mask),
    .diff    (chk_diff)
  );

  // Index of the vector under check, derived from the already-saturated counts.
  always_comb begin
    vec_sum = {1'b0, pass_q} + {1'b0, fail_q};
    vec_idx = vec_sum[CNT_W] ? CNT_MAX : vec_sum[CNT_W-1:0];
  end

  always_comb begin
    state_d      = state_q;
    cap_a_d      = cap_a_q;
    cap_b_d      = cap_b_q;
    cap_out_d    = cap_out_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    sticky_d     = sticky_q;
    ff_a_d       = ff_a_q;
    ff_b_d       = ff_b_q;
    ff_out_d     = ff_out_q;
    ff_idx_d     = ff_idx_q;
    mask_d       = mask_q;
    pend_d       = pend_q;
    in_ready     = 1'b0;
    report_valid = 1'b0;
    mismatch     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cap_a_d   = InpA;
          cap_b_d   = InpB;
          cap_out_d = dut_out;
          pend_d    = finish;
          state_d   = ST_CHECK;
        end else if (finish) begin
          state_d = ST_REPORT;
        end
      end
      ST_CHECK: begin
        mask_d = chk_mask;
        if (!chk_diff) begin
          pass_d = (pass_q == CNT_MAX) ? pass_q : pass_q + CNT_ONE;
        end else begin
          mismatch = 1'b1;
          fail_d   = (fail_q == CNT_MAX) ? fail_q : fail_q + CNT_ONE;
          if (!sticky_q) begin
            sticky_d = 1'b1;
            ff_a_d   = cap_a_q;
            ff_b_d   = cap_b_q;
            ff_out_d = cap_out_q;
            ff_idx_d = vec_idx;
          end
        end
        state_d = (pend_q || finish) ? ST_REPORT : ST_IDLE;
      end
      ST_REPORT: begin
        report_valid = 1'b1;
        if (report_ready) begin
          pass_d   = '0;
          fail_d   = '0;
          sticky_d = 1'b0;
          ff_a_d   = '0;
          ff_b_d   = '0;
          ff_out_d = '0;
          ff_idx_d = '0;
          mask_d   = '0;
          pend_d   = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cap_a_q   <= '0;
      cap_b_q   <= '0;
      cap_out_q <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      sticky_q  <= 1'b0;
      ff_a_q    <= '0;
      ff_b_q    <= '0;
      ff_out_q  <= '0;
      ff_idx_q  <= '0;
      mask_q    <= '0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cap_a_q   <= cap_a_d;
      cap_b_q   <= cap_b_d;
      cap_out_q <= cap_out_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      sticky_q  <= sticky_d;
      ff_a_q    <= ff_a_d;
      ff_b_q    <= ff_b_d;
      ff_out_q  <= ff_out_d;
      ff_idx_q  <= ff_idx_d;
      mask_q    <= mask_d;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    pass_cnt       = pass_q;
    fail_cnt       = fail_q;
    err_sticky     = sticky_q;
    first_fail_a   = ff_a_q;
    first_fail_b   = ff_b_q;
    first_fail_out = ff_out_q;
    first_fail_idx = ff_idx_q;
    mismatch_mask  = mask_q;
    dbg_state      = state_q;
  end

endmodule
